axi4_burst_mem_slave: RTL and testbench

Parametrised AXI4 memory slave that serves as the memory-side endpoint behind the AXI4 master in our `axi4_top` design. It supports FIXED, INCR and WRAP bursts up to 256 beats, byte strobes, narrow transfer sizes, and IDs. It returns SLVERR for out-of-range and illegal requests. Read and write channels run independently, so a read burst can overlap a write burst.

---
 rtl/axi4_pkg.sv | 18 +
 rtl/axi4_burst_mem_slave_if.sv | 56 +++++
 rtl/axi4_addr_gen.sv | 36 +++
 rtl/axi4_burst_mem_slave.sv | 170 +++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared encodings, FSM states and burst helpers for the AXI4 memory slave
package axi4_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// rtl/axi4_burst_mem_slave_if.sv - AXI4 bus bundle between a master and the memory slave
interface axi4_burst_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_addr_gen.sv
// rtl/axi4_addr_gen.sv - next beat address and burst-level legality for one AXI4 burst
module axi4_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              burst_err
);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] container;

  always_comb begin
    bytes     = ADDR_W'(1) << size;
    container = ADDR_W'({1'b0, len} + 9'd1) * bytes;
    next_addr = addr;
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = (addr & ~(bytes - 1'b1)) + bytes;
      // Wrap keeps the container-aligned base and lets only the low bits roll over
      WRAP:    next_addr = (addr & ~(container - 1'b1)) | ((addr + bytes) & (container - 1'b1));
      default: next_addr = addr;
    endcase
    burst_err = (burst == 2'b11)
             || ((burst == WRAP) && !wrap_len_ok(len))
             || (size > 3'(MAX_SIZE));
  end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// rtl/axi4_burst_mem_slave.sv - AXI4 burst memory slave with independent read and write engines
module axi4_burst_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4
) (
  input logic                  clk,
  input logic                  reset,
  axi4_burst_mem_slave_if.slave s
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int MEM_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_addr_nxt, w_idx;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, w_burst_err, w_beat_err;
  logic              aw_hs, w_hs;

  r_state_t          r_state, r_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_addr_nxt, r_idx;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_burst_err, r_beat_err;
  logic              ar_hs, r_hs;

  axi4_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_gen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
    .next_addr(w_addr_nxt), .burst_err(w_burst_err)
  );

  axi4_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_r_gen (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst),
    .next_addr(r_addr_nxt), .burst_err(r_burst_err)
  );

  assign w_idx      = w_addr >> OFF_W;
  assign w_beat_err = w_burst_err || (w_idx >= ADDR_W'(DEPTH));
  assign aw_hs      = s.awvalid && s.awready;
  assign w_hs       = s.wvalid && s.wready;

  // Handshake outputs are gated by reset so they drop in the same cycle reset asserts
  always_comb begin
    w_state_nxt = w_state;
    s.awready   = 1'b0;
    s.wready    = 1'b0;
    s.bvalid    = 1'b0;
    case (w_state)
      W_IDLE: begin
        s.awready = reset;
        if (s.awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s.wready = reset;
        if (s.wvalid && (w_cnt == w_len)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s.bvalid = reset;
        if (s.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s.awid;
      w_addr  <= s.awaddr;
      w_len   <= s.awlen;
      w_size  <= s.awsize;
      w_burst <= s.awburst;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr_nxt;
      w_cnt  <= w_cnt + 8'd1;
      if (w_beat_err || (s.wlast && (w_cnt != w_len))) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s.wstrb[b]) mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= s.wdata[8*b +: 8];
      end
    end
  end

  assign s.bid   = s.bvalid ? w_id : '0;
  assign s.bresp = (s.bvalid && w_err) ? SLVERR : OKAY;

  assign r_idx      = r_addr >> OFF_W;
  assign r_beat_err = r_burst_err || (r_idx >= ADDR_W'(DEPTH));
  assign ar_hs      = s.arvalid && s.arready;
  assign r_hs       = s.rvalid && s.rready;

  always_comb begin
    r_state_nxt = r_state;
    s.arready   = 1'b0;
    s.rvalid    = 1'b0;
    case (r_state)
      R_IDLE: begin
        s.arready = reset;
        if (s.arvalid) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s.rvalid = reset;
        if (s.rready && (r_cnt == r_len)) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else if (ar_hs) begin
      r_id    <= s.arid;
      r_addr  <= s.araddr;
      r_len   <= s.arlen;
      r_size  <= s.arsize;
      r_burst <= s.arburst;
      r_cnt   <= '0;
    end else if (r_hs) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Asynchronous read: a write landing on the same word this cycle is seen only next cycle
  assign s.rid   = s.rvalid ? r_id : '0;
  assign s.rdata = (s.rvalid && !r_beat_err) ? mem[r_idx[MEM_AW-1:0]] : '0;
  assign s.rresp = (s.rvalid && r_beat_err) ? SLVERR : OKAY;
  assign s.rlast = s.rvalid && (r_cnt == r_len);

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// tb/tb_axi4_burst_mem_slave.sv - directed self-checking bench for axi4_burst_mem_slave
module tb_axi4_burst_mem_slave;
  localparam logic [1:0] EXP_OKAY = 2'b00;
  localparam logic [1:0] EXP_SLV  = 2'b10;
  localparam logic [1:0] B_FIXED  = 2'b00;
  localparam logic [1:0] B_INCR   = 2'b01;
  localparam logic [1:0] B_WRAP   = 2'b10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_burst_mem_slave_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) bus ();

  axi4_burst_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .ID_W(4)) dut (
    .clk(clk), .reset(reset), .s(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [3:0]  ridbuf [16];
  int          wlast_at = -1;
  logic [3:0]  cur_id = 4'h0;
  logic        stable_ok;

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, output logic [1:0] resp, output logic [3:0] bid_o,
                          output logic timely);
    int n;
    bus.awid = cur_id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1; bus.wdata = wbuf[0]; bus.wstrb = sbuf[0]; bus.wlast = 1'b0;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL aw_wait timed out"); end
    timely = (bus.wready === 1'b0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    timely = timely && (bus.wready === 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = sbuf[i];
      bus.wlast = (i == ((wlast_at >= 0) ? wlast_at : int'(len)));
      n = 0;
      while (bus.wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n == 50) begin checks++; failures++; $display("FAIL w_wait timed out beat %0d", i); end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    timely = timely && (bus.bvalid === 1'b1);
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL b_wait timed out"); end
    resp = bus.bresp; bid_o = bus.bid;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input int stall_at, output logic timely);
    int n;
    bus.arid = cur_id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL ar_wait timed out"); end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    timely = (bus.rvalid === 1'b1);
    bus.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (bus.rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n == 50) begin checks++; failures++; $display("FAIL r_wait timed out beat %0d", i); end
      rbuf[i] = bus.rdata; rrbuf[i] = bus.rresp; rlbuf[i] = bus.rlast; ridbuf[i] = bus.rid;
      if (i == stall_at) begin
        bus.rready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          if (bus.rvalid !== 1'b1 || bus.rdata !== rbuf[i] || bus.rresp !== rrbuf[i] ||
              bus.rlast !== rlbuf[i] || bus.rid !== ridbuf[i]) stable_ok = 1'b0;
        end
        bus.rready = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0]  hs;
    logic [44:0] outs;
    hs   = {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid};
    outs = {bus.bid, bus.bresp, bus.rid, bus.rdata, bus.rresp, bus.rlast};
    checks++; if (hs !== 5'b0) begin failures++; $display("FAIL reset_handshakes got=%b exp=0", hs); end
    checks++; if (outs !== 45'b0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    reset = 1'b1; #1;
    checks++; if ({bus.awready, bus.arready} !== 2'b11) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=11", {bus.awready, bus.arready}); end
  endtask

  task automatic test_fixed();
    logic [1:0] resp; logic [3:0] bid; logic t;
    cur_id = 4'h5; wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    wr_burst(32'h0, 8'd0, B_FIXED, 3'd2, resp, bid, t);
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL fixed_w_timing got=%b exp=1", t); end
    checks++; if (resp !== EXP_OKAY) begin failures++; $display("FAIL fixed_bresp got=%b exp=%b", resp, EXP_OKAY); end
    checks++; if (bid !== 4'h5) begin failures++; $display("FAIL fixed_bid got=%h exp=5", bid); end
    cur_id = 4'h9;
    rd_burst(32'h0, 8'd0, B_FIXED, 3'd2, -1, t);
    checks++; if (t !== 1'b1) begin failures++; $display("FAIL fixed_r_timing got=%b exp=1", t); end
    checks++; if ({rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]} !== {32'hDEADBEEF, EXP_OKAY, 1'b1, 4'h9}) begin
      failures++; $display("FAIL fixed_read got=%h/%b/%b/%h exp=deadbeef/00/1/9", rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]); end
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [3:0] bid; logic t;
    for (int i = 0; i < 6; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    wr_burst(32'h4, 8'd5, B_INCR, 3'd2, resp, bid, t);
    checks++; if (resp !== EXP_OKAY) begin failures++; $display("FAIL incr_bresp got=%b exp=%b", resp, EXP_OKAY); end
    rd_burst(32'h4, 8'd5, B_INCR, 3'd2, -1, t);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rbuf[i] !== 32'(i + 1) || rlbuf[i] !== (i == 5)) begin
        failures++; $display("FAIL incr_beat%0d got=%h last=%b exp=%h last=%b", i, rbuf[i], rlbuf[i], i + 1, i == 5); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp; logic [3:0] bid; logic t;
    logic [31:0] exp_lin [8] = '{32'h104, 32'h105, 32'h106, 32'h107, 32'h100, 32'h101, 32'h102, 32'h103};
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h100 + 32'(i); sbuf[i] = 4'hF; end
    wr_burst(32'h30, 8'd7, B_WRAP, 3'd2, resp, bid, t);
    checks++; if (resp !== EXP_OKAY) begin failures++; $display("FAIL wrap_bresp got=%b exp=%b", resp, EXP_OKAY); end
    rd_burst(32'h20, 8'd7, B_INCR, 3'd2, -1, t);
    for (int i = 0; i < 8; i++) begin
      checks++; if (rbuf[i] !== exp_lin[i]) begin
        failures++; $display("FAIL wrap_word%0d got=%h exp=%h", i, rbuf[i], exp_lin[i]); end
    end
    rd_burst(32'h30, 8'd7, B_WRAP, 3'd2, -1, t);
    checks++; if (rbuf[4] !== 32'h104 || rbuf[7] !== 32'h107 || rlbuf[7] !== 1'b1) begin
      failures++; $display("FAIL wrap_read got=%h,%h last=%b exp=104,107 last=1", rbuf[4], rbuf[7], rlbuf[7]); end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] bid; logic t;
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'h55 + 32'(i); sbuf[i] = 4'hF; end
    wr_burst(32'h40, 8'd2, B_INCR, 3'd2, resp, bid, t);
    for (int i = 0; i < 3; i++) wbuf[i] = 32'hEE;
    wr_burst(32'h40, 8'd2, B_WRAP, 3'd2, resp, bid, t);
    checks++; if (resp !== EXP_SLV) begin failures++; $display("FAIL wrap_len2_bresp got=%b exp=%b", resp, EXP_SLV); end
    rd_burst(32'h40, 8'd2, B_INCR, 3'd2, -1, t);
    checks++; if ({rbuf[0], rbuf[1], rbuf[2]} !== {32'h55, 32'h56, 32'h57}) begin
      failures++; $display("FAIL wrap_len2_mem got=%h %h %h exp=55 56 57", rbuf[0], rbuf[1], rbuf[2]); end
    wr_burst(32'h60, 8'd0, B_INCR, 3'd3, resp, bid, t);
    checks++; if (resp !== EXP_SLV) begin failures++; $display("FAIL size_bresp got=%b exp=%b", resp, EXP_SLV); end
    wr_burst(32'h60, 8'd0, 2'b11, 3'd2, resp, bid, t);
    checks++; if (resp !== EXP_SLV) begin failures++; $display("FAIL burst11_bresp got=%b exp=%b", resp, EXP_SLV); end
    wlast_at = 0;
    wr_burst(32'h68, 8'd1, B_INCR, 3'd2, resp, bid, t);
    wlast_at = -1;
    checks++; if (resp !== EXP_SLV || t !== 1'b1) begin
      failures++; $display("FAIL early_wlast got=%b timing=%b exp=%b timing=1", resp, t, EXP_SLV); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] bid; logic t;
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    wr_burst(32'h10, 8'd0, B_INCR, 3'd2, resp, bid, t);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    wr_burst(32'h10, 8'd0, B_INCR, 3'd2, resp, bid, t);
    rd_burst(32'h10, 8'd0, B_INCR, 3'd2, -1, t);
    checks++; if (rbuf[0] !== 32'h11BB33DD) begin failures++; $display("FAIL strobe got=%h exp=11bb33dd", rbuf[0]); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [3:0] bid; logic t;
    logic [1:0] exp_r [4] = '{2'b00, 2'b00, 2'b10, 2'b10};
    logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    wr_burst(32'h3F8, 8'd3, B_INCR, 3'd2, resp, bid, t);
    checks++; if (resp !== EXP_SLV) begin failures++; $display("FAIL oor_bresp got=%b exp=%b", resp, EXP_SLV); end
    rd_burst(32'h3F8, 8'd3, B_INCR, 3'd2, -1, t);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rrbuf[i] !== exp_r[i] || rbuf[i] !== exp_d[i]) begin
        failures++; $display("FAIL oor_beat%0d got=%b/%h exp=%b/%h", i, rrbuf[i], rbuf[i], exp_r[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [3:0] bid; logic t;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hB0 + 32'(i); sbuf[i] = 4'hF; end
    wr_burst(32'h80, 8'd3, B_INCR, 3'd2, resp, bid, t);
    stable_ok = 1'b1;
    rd_burst(32'h80, 8'd3, B_INCR, 3'd2, 1, t);
    checks++; if (stable_ok !== 1'b1) begin failures++; $display("FAIL stall_stable got=%b exp=1", stable_ok); end
    checks++; if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !== {32'hB0, 32'hB1, 32'hB2, 32'hB3} || rlbuf[3] !== 1'b1) begin
      failures++; $display("FAIL stall_data got=%h %h %h %h exp=b0 b1 b2 b3", rbuf[0], rbuf[1], rbuf[2], rbuf[3]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [3:0] bid; logic tw, tr;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
    fork
      wr_burst(32'h100, 8'd3, B_INCR, 3'd2, resp, bid, tw);
      rd_burst(32'h0, 8'd0, B_FIXED, 3'd2, -1, tr);
    join
    checks++; if (resp !== EXP_OKAY || tw !== 1'b1) begin
      failures++; $display("FAIL overlap_write got=%b timing=%b exp=%b timing=1", resp, tw, EXP_OKAY); end
    checks++; if (rbuf[0] !== 32'hDEADBEEF || tr !== 1'b1) begin
      failures++; $display("FAIL overlap_read got=%h timing=%b exp=deadbeef timing=1", rbuf[0], tr); end
    rd_burst(32'h100, 8'd3, B_INCR, 3'd2, -1, tr);
    checks++; if ({rbuf[0], rbuf[3]} !== {32'hC0, 32'hC3}) begin
      failures++; $display("FAIL overlap_mem got=%h %h exp=c0 c3", rbuf[0], rbuf[3]); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] bid; logic t;
    bus.awid = 4'h3; bus.awaddr = 32'hA0; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = B_INCR;
    bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wlast = 1'b0;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    reset = 1'b0; #1;
    checks++; if ({bus.awready, bus.wready, bus.bvalid} !== 3'b000) begin
      failures++; $display("FAIL midreset_now got=%b exp=000", {bus.awready, bus.wready, bus.bvalid}); end
    @(posedge clk); #1;
    checks++; if ({bus.awready, bus.bvalid} !== 2'b00) begin
      failures++; $display("FAIL midreset_held got=%b exp=00", {bus.awready, bus.bvalid}); end
    @(posedge clk); #1;
    reset = 1'b1; #1;
    checks++; if (bus.awready !== 1'b1) begin failures++; $display("FAIL midreset_release got=%b exp=1", bus.awready); end
    wbuf[0] = 32'h88; sbuf[0] = 4'hF;
    wr_burst(32'hC0, 8'd0, B_INCR, 3'd2, resp, bid, t);
    checks++; if (resp !== EXP_OKAY) begin failures++; $display("FAIL midreset_new_bresp got=%b exp=%b", resp, EXP_OKAY); end
    rd_burst(32'hA0, 8'd0, B_INCR, 3'd2, -1, t);
    checks++; if (rbuf[0] !== 32'h77) begin failures++; $display("FAIL midreset_kept got=%h exp=77", rbuf[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    test_fixed();
    test_incr();
    test_wrap();
    test_errors();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
